md_unit_iter: RTL and testbench
===============================

// Module: md_unit_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit; next generation of the core's HI/LO unit.
//  Radix-2 shift-add multiply and restoring divide replace single-cycle '*' and '/'.
//  Adds flush (exception cancel), a done pulse and signed-overflow handling.
//  Sits in EX beside the ALU; the hazard unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; even, >= 4
// PORTS
//  clk    in   1      clock, rising edge
//  reset  in   1      asynchronous, active-low reset
//  start  in   1      issue op this cycle; honoured only in IDLE and with flush=0
//  op     in   4      0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd,8 maddu,9 msub
//  d1     in   WIDTH  rs operand (mthi/mtlo source)
//  d2     in   WIDTH  rt operand
//  flush  in   1      abort in-flight op; HI/LO untouched
//  busy   out  1      (state!=IDLE) | (start & op in 1..4,7..9)
//  done   out  1      one-cycle pulse in the cycle after HI/LO commit
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, hi=lo=0, done=0, counter=0, busy=0 once start=0.
//  FSM: IDLE -> CALC (start, arith op) -> FIX (counter==WIDTH-1) -> IDLE.
//  IDLE: latch |d1|,|d2|, sign flags and op; counter=0. Unsigned ops use raw operands.
//  CALC: one partial-product add or one trial subtraction per cycle; WIDTH cycles.
//  FIX: negate results per sign flags; commit {hi,lo} at end of FIX; done=1 next cycle.
//  Latency: start accepted at edge T. CALC spans WIDTH cycles, FIX 1 cycle, so busy is
//   high for WIDTH+2 cycles including the start cycle. New hi/lo is visible at cycle T+WIDTH+2.
//  mult/multu: {hi,lo} = 2*WIDTH-bit product, signed or unsigned.
//  div/divu: lo = quotient truncated toward 0; hi = remainder with sign of dividend.
//  Divide by zero: full latency, no commit, done still pulses, hi/lo unchanged.
//  div MIN / -1: lo = MIN (0x80000000 at WIDTH=32), hi = 0; no trap.
//  mthi/mtlo: single cycle; write d1 at the edge; busy only from the start term; no done.
//  start while busy: ignored entirely; the op is neither queued nor latched.
//  flush: IDLE at next edge from any state; no commit, no done. flush+start in same cycle:
//   nothing starts. flush in IDLE: no effect.
//  flush during the FIX cycle: the abort wins and there is no commit.
//  reset mid-op: immediate IDLE; hi=lo=0.
//  op=0 or an undefined code with start: no-op; busy follows the start term.
// CONFIGURATION
//  MD_MADD_EN defined: op 7/8/9 are legal.
//   {hi,lo} +=/-= signed or unsigned product, applied in FIX, modulo 2^(2*WIDTH).
//   Same latency as mult.
//  MD_MADD_EN undefined: op 7..9 behave as op=0 (no busy, no change); accumulator
//   logic absent.
// TESTING
//  1 mult d1=0xFFFFFFFF d2=2 -> busy 34 cycles; hi=0xFFFFFFFF lo=0xFFFFFFFE; one done pulse
//  2 multu d1=0xFFFFFFFF d2=2 -> hi=0x00000001 lo=0xFFFFFFFE
//  3 div d1=-7 d2=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    div 0x80000000/-1 -> lo=0x80000000 hi=0
//  4 mtlo 5, then divu d1=9 d2=0 -> after 34 cycles lo=5, hi unchanged; done=1
//  5 div 100/7 then flush at CALC cycle 5 -> busy=0 next cycle; hi/lo unchanged; no done.
//    start during busy is ignored
//  6 mult in flight, reset low mid-CALC -> hi=lo=0 and busy=0 immediately.
//    With MD_MADD_EN: hi=0 lo=10, madd 3*4 -> lo=22

Source files
------------

// File: rtl/md_unit_iter.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, flush, done pulse.
// Optional multiply-accumulate ops (madd/maddu/msub) are built when MD_MADD_EN is defined.
module md_unit_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

    function automatic logic is_arith(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB:         return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [3:0] o);
        case (o)
            OP_MULT, OP_DIV: return 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MSUB: return 1'b1;
`endif
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Two's-complement magnitude; MIN maps to 2^(WIDTH-1), which is exact as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? $signed(~v + 1'b1) : $signed(v);
    endfunction

    logic [1:0]             state;
    logic [CW-1:0]          count;
    logic [3:0]             op_q;
    logic                   neg_a;
    logic                   neg_b;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       acc_hi;
    logic [WIDTH-1:0]       acc_lo;

    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_trial;
    logic signed [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0]     res;
    logic                   commit;
    logic                   sgn_in;

    assign busy   = (state != S_IDLE) | (start & is_arith(op));
    assign sgn_in = is_signed_op(op);

    // Iteration datapath: shift-add keeps the product in {acc_hi, acc_lo};
    // restoring divide keeps remainder in acc_hi and shifts quotient bits into acc_lo.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};

    always_comb begin
        prod = neg_2w({acc_hi, acc_lo}, neg_a ^ neg_b);
        res  = prod;
        if (is_div_op(op_q)) begin
            res = {neg_w(acc_hi, neg_a), neg_w(acc_lo, neg_a ^ neg_b)};
        end
`ifdef MD_MADD_EN
        else if (op_q == OP_MADD || op_q == OP_MADDU) begin
            res = {hi, lo} + prod;
        end else if (op_q == OP_MSUB) begin
            res = {hi, lo} - prod;
        end
`endif
    end

    // Divide by zero runs the full latency but leaves HI/LO alone.
    assign commit = !(is_div_op(op_q) && (opb == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= '0;
            op_q  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    count <= '0;
                    if (start && !flush) begin
                        if (is_arith(op)) begin
                            state <= S_CALC;
                            op_q  <= op;
                            neg_a <= sgn_in & d1[WIDTH-1];
                            neg_b <= sgn_in & d2[WIDTH-1];
                        end else if (op == OP_MTHI) begin
                            hi <= d1;
                        end else if (op == OP_MTLO) begin
                            lo <= d1;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (count == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (commit) begin
                            hi <= res[2*WIDTH-1:WIDTH];
                            lo <= res[WIDTH-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            acc_hi <= '0;
            if (is_div_op(op)) begin
                opb    <= magnitude(d2, sgn_in);
                acc_lo <= magnitude(d1, sgn_in);
            end else begin
                opb    <= magnitude(d1, sgn_in);
                acc_lo <= magnitude(d2, sgn_in);
            end
        end else if (state == S_CALC) begin
            if (is_div_op(op_q)) begin
                if (!div_trial[WIDTH]) begin
                    acc_hi <= div_trial[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_md_unit_iter.sv
// Randomized bench for md_unit_iter against a plain-arithmetic HI/LO model.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] d1, d2;
    logic         flush;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    md_unit_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_arith(input logic [3:0] o);
`ifdef MD_MADD_EN
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd9);
`else
        return (o >= 4'd1 && o <= 4'd4);
`endif
    endfunction

    // New {hi,lo} for an arithmetic op, from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [3:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic [63:0] old);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            4'd1: p = 64'(sa * sb);
            4'd2: p = ua * ub;
            4'd3: begin
                if (b == 0) return old;
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return old;
                p = {a % b, a / b};
            end
            4'd7: p = old + 64'(sa * sb);
            4'd8: p = old + ua * ub;
            4'd9: p = old - 64'(sa * sb);
            default: p = old;
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit arith;
        int cycles;
        logic [63:0] exp;
        arith = model_arith(o);
        exp = model_result(o, a, b, {m_hi, m_lo});
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b;
        #1 check($sformatf("busy_start op%0d", o), 64'(busy), 64'(arith));
        @(posedge clk);
        #1 start = 1'b0; op = 4'd0;
        if (!arith) begin
            if (o == 4'd5) m_hi = a;
            if (o == 4'd6) m_lo = a;
            @(negedge clk);
            check($sformatf("busy_after op%0d", o), 64'(busy), 64'd0);
            check($sformatf("done op%0d", o), 64'(done), 64'd0);
            check($sformatf("hilo op%0d", o), {hi, lo}, {m_hi, m_lo});
            return;
        end
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        {m_hi, m_lo} = exp;
        check($sformatf("busy_len op%0d", o), 64'(cycles), 64'(W + 1));
        check($sformatf("done op%0d", o), 64'(done), 64'd1);
        check($sformatf("hilo op%0d a=%h b=%h", o, a, b), {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        check($sformatf("done_pulse op%0d", o), 64'(done), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int dcount;
        reset = 1'b0; start = 1'b0; op = '0; d1 = '0; d2 = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        check("t1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        check("t2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(4'd3, -32'sd7, 32'd2);
        check("t3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("t3_min", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'd6, 32'd5, 32'd0);
        run_op(4'd4, 32'd9, 32'd0);
        check("t4_lo", 64'(lo), 64'd5);

        // flush at CALC cycle 5, plus an ignored start while busy
        run_op(4'd5, 32'h1234_5678, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd3; d1 = 32'd100; d2 = 32'd7;
        @(posedge clk);
        #1 op = 4'd5; d1 = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        start = 1'b0; op = 4'd0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, {m_hi, m_lo});
        dcount = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush_no_done", 64'(dcount), 64'd0);

        // flush in the FIX cycle
        @(negedge clk);
        start = 1'b1; op = 4'd1; d1 = 32'd3; d2 = 32'd5;
        @(posedge clk);
        #1 start = 1'b0; op = 4'd0;
        repeat (W + 1) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fixflush_done", 64'(done), 64'd0);
        check("fixflush_hilo", {hi, lo}, {m_hi, m_lo});

        // flush and start together
        @(negedge clk);
        start = 1'b1; op = 4'd2; d1 = 32'd7; d2 = 32'd9; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; op = 4'd0; flush = 1'b0;
        @(negedge clk);
        check("flushstart_busy", 64'(busy), 64'd0);

        // ignored start: mult in flight with mthi attempt
        @(negedge clk);
        start = 1'b1; op = 4'd2; d1 = 32'd6; d2 = 32'd7;
        @(posedge clk);
        #1 op = 4'd5; d1 = 32'hCAFE_0000;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        while (busy) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd42;
        check("ignored_start", {hi, lo}, {m_hi, m_lo});

`ifdef MD_MADD_EN
        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'd10, 32'd0);
        run_op(4'd7, 32'd3, 32'd4);
        check("madd_const", {hi, lo}, 64'd22);
`else
        run_op(4'd7, 32'd3, 32'd4);
`endif

        for (int i = 0; i < 30; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick());
        end

        // reset mid-CALC
        @(negedge clk);
        start = 1'b1; op = 4'd1; d1 = 32'd11; d2 = 32'd13;
        @(posedge clk);
        #1 start = 1'b0; op = 4'd0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1 check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op(4'd4, 32'd100, 32'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
